vga_anim_sequencer: RTL and testbench
=====================================

// Module: vga_anim_sequencer
// PURPOSE
//  Frame-synchronous animation controller for the VGA demo pattern datapath.
//  Replaces the ad-hoc vsync-clocked frame counter with a clk-domain sequencer.
//  It generates the animation counter that drives the layered pattern generator,
//  with run/pause, single-step, speed prescaling, direction, and wrap or ping-pong.
//  Sits between hvsync_generator (vsync in) and the pattern datapath (anim_cnt out).
// PARAMETERS
//  CNT_W      10  width of anim_cnt and cnt_max
//  VSYNC_POL  0   vsync active level (0 = active-low pulse, 1 = active-high)
// PORTS
//  clk        in   1      pixel clock (25.175 MHz); all logic on posedge
//  rst_n      in   1      reset, synchronous, active-low
//  vsync      in   1      vsync from hvsync_generator, same clock domain
//  run_en     in   1      level: 1 = free-run, 0 = pause
//  step       in   1      level; rising edge requests one advance while paused
//  dir        in   1      requested direction: 0 = up, 1 = down
//  pingpong   in   1      0 = wrap at limits, 1 = reverse at limits
//  speed      in   4      frames per advance minus 1 (0 = every frame)
//  cnt_max    in   CNT_W  inclusive upper limit of anim_cnt
//  anim_cnt   out  CNT_W  animation counter to the pattern datapath
//  frame_tick out  1      1-cycle pulse at each vsync assertion
//  advance    out  1      1-cycle pulse in the cycle anim_cnt changes
//  state      out  2      0 = PAUSE, 1 = RUN, 2 = STEP_ARMED
//  dir_now    out  1      effective direction (differs from dir after a ping-pong flip)
//  rnd        out  8      pseudo-random byte (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): anim_cnt=0, frame_tick=0, advance=0, state=PAUSE,
//   dir_now=dir, prescale=0, vsync_q=inactive level, step_q=1 (no spurious edge).
//   Reset mid-operation aborts everything: no pending step, prescale cleared.
//  frame_tick = vsync at active level AND vsync_q inactive; registered, 1 cycle late.
//  step_rise = step & ~step_q. step is sampled every cycle.
//  FSM (evaluated every cycle; run_en has priority over step):
//   PAUSE      -> RUN if run_en; else -> STEP_ARMED on step_rise.
//   RUN        -> PAUSE if !run_en. Prescale is held, not cleared.
//   STEP_ARMED -> RUN if run_en. On a frame_tick, advance once, clear prescale,
//                 and go to PAUSE.
//   A step_rise in the same cycle as a frame_tick in PAUSE arms only. The advance
//    happens on the next frame_tick. step_rise in RUN or STEP_ARMED is ignored.
//  Prescale (RUN only): on frame_tick, if prescale>=speed then advance and
//   prescale=0; else prescale+1. A speed change takes effect at the next tick.
//  Advance (next anim_cnt, with d = dir_now):
//   cnt_max==0                  -> anim_cnt=0; advance still pulses.
//   anim_cnt>cnt_max (max lowered) -> load 0 if up, cnt_max if down.
//   up, anim_cnt<cnt_max        -> +1.   down, anim_cnt>0 -> -1.
//   up at cnt_max:  wrap -> 0;       pingpong -> cnt_max-1, dir_now=1.
//   down at 0:      wrap -> cnt_max; pingpong -> 1,         dir_now=0.
//  dir_now follows the dir input on any change of dir (edge-compared with a
//   registered copy); a ping-pong flip overrides it until dir next changes.
//  anim_cnt, advance, and dir_now update in the cycle after the frame_tick pulse.
//   Latency from vsync assertion to anim_cnt change = 2 clk.
//  All arithmetic is unsigned CNT_W, with no carry out.
// CONFIGURATION
//  ANIM_LFSR_EN defined: rnd is an 8-bit Galois LFSR, taps 0xB8, reset 8'hA5.
//   It shifts once per advance pulse only, so the sequence is reproducible per
//   animation step.
//  Not defined: rnd is tied to 8'h00 and no LFSR flops are built.
// TESTING
//  1. Reset, run_en=1, speed=0, cnt_max=5, dir=0, 8 vsync pulses
//     -> anim_cnt 1,2,3,4,5,0,1,2; advance pulses 8 times.
//  2. speed=3, run_en=1, 8 frames
//     -> exactly 2 advances, on frames 4 and 8; anim_cnt=2.
//  3. pingpong=1, cnt_max=3, speed=0, 8 frames from 0
//     -> 1,2,3,2,1,0,1,2; dir_now toggles at 3 and at 0.
//  4. run_en=0, step rise coincident with frame_tick
//     -> no change that frame; next frame anim_cnt+1; state returns to 0.
//  5. cnt_max lowered 9->4 while anim_cnt=7, dir=0
//     -> next advance gives anim_cnt=0. cnt_max=0 -> anim_cnt stays 0.
//  6. rst_n=0 for 1 clk mid-run at anim_cnt=6, STEP_ARMED pending
//     -> anim_cnt=0, state=PAUSE, no advance on the next vsync.
//     With ANIM_LFSR_EN: rnd=8'hA5, then 8'hEA after the first advance.

Source files
------------

// File: rtl/vga_anim_sequencer.sv
// rtl/vga_anim_sequencer.sv - frame-synchronous animation counter sequencer (run/pause/step, prescale, wrap/ping-pong)
// Optional pseudo-random byte output built only when ANIM_LFSR_EN is defined.
module vga_anim_sequencer #(
    parameter int CNT_W     = 10,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             run_en,
    input  logic             step,
    input  logic             dir,
    input  logic             pingpong,
    input  logic [3:0]       speed,
    input  logic [CNT_W-1:0] cnt_max,
    output logic [CNT_W-1:0] anim_cnt,
    output logic             frame_tick,
    output logic             advance,
    output logic [1:0]       state,
    output logic             dir_now,
    output logic [7:0]       rnd
);

    typedef enum logic [1:0] {
        ST_PAUSE      = 2'd0,
        ST_RUN        = 2'd1,
        ST_STEP_ARMED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [3:0]       prescale_q, prescale_d;
    logic             dir_now_q, dir_now_d;
    logic             dir_prev_q;
    logic             vsync_q;
    logic             step_q;
    logic             frame_tick_q, frame_tick_d;
    logic             advance_q;
    logic             do_adv;
    logic             step_rise;
    logic             flip;
    logic             flip_dir;

    assign step_rise    = step & ~step_q;
    assign frame_tick_d = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);

    // Run has priority over step; a step arriving with a tick only arms.
    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        do_adv     = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                if (run_en)
                    state_d = ST_RUN;
                else if (step_rise)
                    state_d = ST_STEP_ARMED;
            end
            ST_RUN: begin
                if (!run_en) begin
                    state_d = ST_PAUSE;
                end else if (frame_tick_q) begin
                    if (prescale_q >= speed) begin
                        do_adv     = 1'b1;
                        prescale_d = 4'd0;
                    end else begin
                        prescale_d = prescale_q + 4'd1;
                    end
                end
            end
            ST_STEP_ARMED: begin
                if (run_en) begin
                    state_d = ST_RUN;
                end else if (frame_tick_q) begin
                    do_adv     = 1'b1;
                    prescale_d = 4'd0;
                    state_d    = ST_PAUSE;
                end
            end
            default: state_d = ST_PAUSE;
        endcase
    end

    // Next counter value; an out-of-range count (limit lowered) snaps to the start of travel.
    always_comb begin
        cnt_nxt  = cnt_q;
        flip     = 1'b0;
        flip_dir = dir_now_q;
        if (cnt_max == '0) begin
            cnt_nxt = '0;
        end else if (cnt_q > cnt_max) begin
            cnt_nxt = dir_now_q ? cnt_max : '0;
        end else if (!dir_now_q) begin
            if (cnt_q < cnt_max) begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end else if (pingpong) begin
                cnt_nxt  = cnt_max - CNT_W'(1);
                flip     = 1'b1;
                flip_dir = 1'b1;
            end else begin
                cnt_nxt = '0;
            end
        end else begin
            if (cnt_q != '0) begin
                cnt_nxt = cnt_q - CNT_W'(1);
            end else if (pingpong) begin
                cnt_nxt  = CNT_W'(1);
                flip     = 1'b1;
                flip_dir = 1'b0;
            end else begin
                cnt_nxt = cnt_max;
            end
        end
    end

    always_comb begin
        cnt_d     = do_adv ? cnt_nxt : cnt_q;
        dir_now_d = dir_now_q;
        if (dir != dir_prev_q)
            dir_now_d = dir;
        if (do_adv && flip)
            dir_now_d = flip_dir;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_PAUSE;
            cnt_q        <= '0;
            prescale_q   <= 4'd0;
            dir_now_q    <= dir;
            dir_prev_q   <= dir;
            vsync_q      <= ~VSYNC_POL;
            step_q       <= 1'b1;
            frame_tick_q <= 1'b0;
            advance_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prescale_q   <= prescale_d;
            dir_now_q    <= dir_now_d;
            dir_prev_q   <= dir;
            vsync_q      <= vsync;
            step_q       <= step;
            frame_tick_q <= frame_tick_d;
            advance_q    <= do_adv;
        end
    end

`ifdef ANIM_LFSR_EN
    logic [7:0] lfsr_q;

    // Galois right-shift, taps 0xB8; steps only with the counter so patterns repeat per step.
    always_ff @(posedge clk) begin
        if (!rst_n)
            lfsr_q <= 8'hA5;
        else if (do_adv)
            lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    end

    assign rnd = lfsr_q;
`else
    assign rnd = 8'h00;
`endif

    assign anim_cnt   = cnt_q;
    assign frame_tick = frame_tick_q;
    assign advance    = advance_q;
    assign state      = state_q;
    assign dir_now    = dir_now_q;

endmodule

// File: tb/tb_vga_anim_sequencer.sv
// tb/tb_vga_anim_sequencer.sv - self-checking bench for vga_anim_sequencer with cycle-level reference model
module tb_vga_anim_sequencer;

    localparam int CNT_W = 10;
    localparam bit VP    = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             vsync = ~VP;
    logic             run_en = 1'b0;
    logic             step = 1'b0;
    logic             dir = 1'b0;
    logic             pingpong = 1'b0;
    logic [3:0]       speed = 4'd0;
    logic [CNT_W-1:0] cnt_max = '0;
    logic [CNT_W-1:0] anim_cnt;
    logic             frame_tick;
    logic             advance;
    logic [1:0]       state;
    logic             dir_now;
    logic [7:0]       rnd;

    vga_anim_sequencer #(.CNT_W(CNT_W), .VSYNC_POL(VP)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .run_en(run_en), .step(step),
        .dir(dir), .pingpong(pingpong), .speed(speed), .cnt_max(cnt_max),
        .anim_cnt(anim_cnt), .frame_tick(frame_tick), .advance(advance),
        .state(state), .dir_now(dir_now), .rnd(rnd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int adv_seen = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: states 0 PAUSE, 1 RUN, 2 STEP_ARMED; counts kept as plain ints.
    bit m_valid = 0;
    int m_cnt, m_state, m_pre, m_rnd;
    bit m_tick, m_adv, m_dirnow, m_dirprev, m_vs_prev, m_step_prev;
    int ns, npre, nc, mx;
    bit go, fl, fdir, rise;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1; m_cnt = 0; m_state = 0; m_pre = 0; m_tick = 0; m_adv = 0;
            m_dirnow = dir; m_dirprev = dir; m_vs_prev = ~VP; m_step_prev = 1;
`ifdef ANIM_LFSR_EN
            m_rnd = 8'hA5;
`else
            m_rnd = 0;
`endif
        end else begin
            go = 0; ns = m_state; npre = m_pre; rise = step && !m_step_prev;
            case (m_state)
                0: if (run_en) ns = 1; else if (rise) ns = 2;
                1: if (!run_en) ns = 0;
                   else if (m_tick) begin
                       if (m_pre >= int'(speed)) begin go = 1; npre = 0; end
                       else npre = m_pre + 1;
                   end
                default: if (run_en) ns = 1;
                         else if (m_tick) begin go = 1; npre = 0; ns = 0; end
            endcase
            nc = m_cnt; fl = 0; fdir = m_dirnow; mx = int'(cnt_max);
            if (go) begin
                if (mx == 0) nc = 0;
                else if (nc > mx) nc = m_dirnow ? mx : 0;
                else if (!pingpong) nc = m_dirnow ? (nc + mx) % (mx + 1) : (nc + 1) % (mx + 1);
                else if (!m_dirnow && nc == mx) begin nc = mx - 1; fl = 1; fdir = 1; end
                else if (m_dirnow && nc == 0) begin nc = 1; fl = 1; fdir = 0; end
                else nc = m_dirnow ? nc - 1 : nc + 1;
`ifdef ANIM_LFSR_EN
                m_rnd = (m_rnd >> 1) ^ ((m_rnd % 2 == 1) ? 8'hB8 : 0);
`endif
            end
            if (dir != m_dirprev) m_dirnow = dir;
            if (fl) m_dirnow = fdir;
            m_adv = go; m_cnt = nc; m_state = ns; m_pre = npre;
            m_tick = (vsync == VP) && (m_vs_prev != VP);
            m_vs_prev = vsync; m_step_prev = step; m_dirprev = dir;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("anim_cnt", int'(anim_cnt), m_cnt);
            chk("frame_tick", int'(frame_tick), int'(m_tick));
            chk("advance", int'(advance), int'(m_adv));
            chk("state", int'(state), m_state);
            chk("dir_now", int'(dir_now), int'(m_dirnow));
            chk("rnd", int'(rnd), m_rnd);
        end
        if (advance) adv_seen++;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_frame();
        vsync = VP; cyc(2);
        vsync = ~VP; cyc(6);
    endtask

    task automatic do_reset();
        rst_n = 0; cyc(2); rst_n = 1;
    endtask

    int exp1[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int exp3[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int dir3[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    int a0;
    int gap, act;

    initial begin
        // 1: reset values, then free-run wrap at 5
        dir = 0; run_en = 0; cyc(1);
        rst_n = 0; cyc(2);
        chk("rst_anim_cnt", int'(anim_cnt), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_advance", int'(advance), 0);
        chk("rst_frame_tick", int'(frame_tick), 0);
        rst_n = 1;
        run_en = 1; speed = 0; cnt_max = 5; cyc(1);
        a0 = adv_seen;
        for (int i = 0; i < 8; i++) begin
            do_frame();
            chk("t1_cnt", int'(anim_cnt), exp1[i]);
        end
        chk("t1_adv_count", adv_seen - a0, 8);

        // 2: prescale 3 -> advances on frames 4 and 8
        do_reset(); speed = 3; cyc(1);
        a0 = adv_seen;
        for (int i = 0; i < 8; i++) do_frame();
        chk("t2_adv_count", adv_seen - a0, 2);
        chk("t2_cnt", int'(anim_cnt), 2);

        // 3: ping-pong between 0 and 3
        do_reset(); speed = 0; pingpong = 1; cnt_max = 3; cyc(1);
        for (int i = 0; i < 8; i++) begin
            do_frame();
            chk("t3_cnt", int'(anim_cnt), exp3[i]);
            chk("t3_dir_now", int'(dir_now), dir3[i]);
        end

        // 4: step rising together with frame_tick only arms
        run_en = 0; cyc(2);
        vsync = VP; cyc(1);
        chk("t4_tick_high", int'(frame_tick), 1);
        step = 1; cyc(1);
        vsync = ~VP; cyc(6);
        chk("t4_cnt_held", int'(anim_cnt), 2);
        chk("t4_armed", int'(state), 2);
        step = 0;
        do_frame();
        chk("t4_cnt_step", int'(anim_cnt), 3);
        chk("t4_state_back", int'(state), 0);

        // 5: limit lowered below the count, then limit of zero
        pingpong = 0; do_reset(); run_en = 1; cnt_max = 9; cyc(1);
        for (int i = 0; i < 7; i++) do_frame();
        chk("t5_cnt7", int'(anim_cnt), 7);
        cnt_max = 4; do_frame();
        chk("t5_lowered", int'(anim_cnt), 0);
        cnt_max = 0; a0 = adv_seen; do_frame();
        chk("t5_zero_max", int'(anim_cnt), 0);
        chk("t5_zero_adv", adv_seen - a0, 1);

        // 6: reset with a step pending cancels it
        do_reset(); run_en = 1; cnt_max = 9; cyc(1);
        for (int i = 0; i < 6; i++) do_frame();
        chk("t6_cnt6", int'(anim_cnt), 6);
        run_en = 0; cyc(2); step = 1; cyc(2);
        chk("t6_armed", int'(state), 2);
        rst_n = 0; cyc(1); rst_n = 1;
        chk("t6_rst_cnt", int'(anim_cnt), 0);
        chk("t6_rst_state", int'(state), 0);
        a0 = adv_seen; do_frame();
        chk("t6_no_adv", adv_seen - a0, 0);
        chk("t6_cnt_still0", int'(anim_cnt), 0);
`ifdef ANIM_LFSR_EN
        chk("t6_rnd_seed", int'(rnd), 8'hA5);
`else
        chk("t6_rnd_off", int'(rnd), 0);
`endif
        step = 0; cyc(1); step = 1; cyc(1);
        do_frame();
        chk("t6_cnt_step", int'(anim_cnt), 1);
`ifdef ANIM_LFSR_EN
        chk("t6_rnd_step", int'(rnd), 8'hEA);
`else
        chk("t6_rnd_off2", int'(rnd), 0);
`endif

        // Randomised phase, checked every cycle by the model
        step = 0;
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 3) == 0) cnt_max = CNT_W'($urandom_range(0, 12));
            speed = 4'($urandom_range(0, 3));
            gap = $urandom_range(3, 10);
            act = $urandom_range(1, 3);
            for (int c = 0; c < act + gap; c++) begin
                vsync = (c < act) ? VP : ~VP;
                if ($urandom_range(0, 39) == 0) run_en = ~run_en;
                if ($urandom_range(0, 49) == 0) dir = ~dir;
                if ($urandom_range(0, 59) == 0) pingpong = ~pingpong;
                if ($urandom_range(0, 5) == 0) step = ~step;
                rst_n = ($urandom_range(0, 299) != 0);
                cyc(1);
            end
        end
        rst_n = 1; cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
